// File: rtl/if_prefetch.sv
// ----------------------------------------------------------------------------
// if_prefetch -- instruction-fetch stage feeding the decode stage.
//
// Issues sequential fetch requests over a req/gnt/rvalid memory interface,
// buffers the in-order responses (word plus issue address) in a small
// show-ahead FIFO, and presents them to decode with valid/ready handshaking.
// A redirect from execute flushes the buffer and restarts fetch at a new PC.
// Responses still in flight for the flushed stream are counted and discarded.
//
// Optional feature (compile-time macro IF_BYPASS_EN):
//   When the FIFO is empty, a live response is forwarded combinationally to
//   decode in the cycle it returns. If decode takes it, it is never pushed.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req_o        fetch request valid
//   imem_addr_o       fetch address (word aligned)
//   imem_gnt_i        request accepted (handshake = req & gnt)
//   imem_rvalid_i     response valid (in order, >= 1 cycle after grant)
//   imem_rdata_i      response instruction word
//   redirect_i        flush and restart fetch at redirect_addr_i
//   redirect_addr_i   new PC (bits [1:0] ignored)
//   id_ready_i        decode accepts the current instruction
//   inst_valid_o      inst_o / inst_addr_o hold a valid instruction
//   inst_o            instruction to decode (NOP_INST when not valid)
//   inst_addr_o       address of inst_o (holds last value when not valid)
// ----------------------------------------------------------------------------
module if_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        id_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   pc_q;         // next address to request
    logic [31:0]   rsp_pc_q;     // address of the next live response
    logic [31:0]   addr_hold_q;  // last address shown to decode
    cnt_t          live_q;       // granted, unreturned, current stream
    cnt_t          drop_q;       // in flight from flushed streams
    cnt_t          count_q;      // FIFO occupancy
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [31:0]   mem_addr [FIFO_DEPTH];

    // Handshake / datapath decisions
    logic        grant;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        bypass;
    logic        bypass_take;
    logic        push;
    logic        pop;
    logic        fifo_valid;
    logic [CW:0] occ_live;
    logic [CW:0] live_drop;
    logic [31:0] redirect_pc;

    assign redirect_pc = redirect_addr_i & ~32'h3;
    assign fifo_valid  = (count_q != '0);

    // Credits: never request more than the FIFO can absorb, and never let
    // the total in flight exceed what the counters are sized for.
    assign occ_live  = {1'b0, count_q} + {1'b0, live_q};
    assign live_drop = {1'b0, live_q} + {1'b0, drop_q};

    assign imem_req_o  = !rst && !redirect_i && (occ_live < DEPTH_C) && (live_drop < DEPTH_C);
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    // Responses from flushed streams come back first (in order), so they are
    // discarded while drop_q is non-zero. A response during a redirect cycle
    // belongs to the old stream and is folded into the new drop count.
    assign rsp_drop = imem_rvalid_i && (drop_q != '0);
    assign rsp_keep = imem_rvalid_i && (drop_q == '0) && !redirect_i;

`ifdef IF_BYPASS_EN
    assign bypass      = rsp_keep && !fifo_valid;
    assign bypass_take = bypass && id_ready_i;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push = rsp_keep && !bypass_take;
    assign pop  = fifo_valid && id_ready_i && !redirect_i;

    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        inst_valid_o = fifo_valid;
        inst_o       = fifo_valid ? mem_data[rd_ptr_q] : NOP_INST;
        inst_addr_o  = fifo_valid ? mem_addr[rd_ptr_q] : addr_hold_q;
        if (bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            inst_addr_o  = rsp_pc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_ADDR;
            rsp_pc_q    <= RESET_ADDR;
            addr_hold_q <= '0;
            live_q      <= '0;
            drop_q      <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            if (inst_valid_o) begin
                addr_hold_q <= inst_addr_o;
            end

            if (redirect_i) begin
                // Everything outstanding now belongs to a dead stream; an
                // rvalid this cycle has already retired one of them.
                pc_q     <= redirect_pc;
                rsp_pc_q <= redirect_pc;
                live_q   <= '0;
                drop_q   <= drop_q + live_q + cnt_t'(grant) - cnt_t'(imem_rvalid_i);
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (grant) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (rsp_keep) begin
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                end
                live_q  <= live_q + cnt_t'(grant) - cnt_t'(rsp_keep);
                drop_q  <= drop_q - cnt_t'(rsp_drop);
                count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // NOTE: buffer storage has no reset; an entry is only read after it has
    // been written, because validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= imem_rdata_i;
            mem_addr[wr_ptr_q] <= rsp_pc_q;
        end
    end

endmodule
